// File: rtl/mac_pkg.sv
// mac_pkg: shared types and default constants for the MAC accumulator.
//   state_t       - accumulator FSM state (ACCUM collects products, DONE presents result)
//   *_DEF         - default parameter values for WIDTH / ACC_WIDTH / N_TERMS
//   CNT_W         - width of the per-batch product counter (o_count)
package mac_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  localparam int WIDTH_DEF     = 4;
  localparam int ACC_WIDTH_DEF = 12;
  localparam int N_TERMS_DEF   = 8;
  localparam int CNT_W         = 8;

endpackage

// File: rtl/acc_add_sat.sv
// acc_add_sat: ACC_WIDTH-bit adder with carry-out and optional clamp.
//   i_a, i_b  - addends (running sum, zero-extended product)
//   o_sum     - wrapped sum, or all-ones on carry when MAC_SATURATE_EN is defined
//   o_carry   - carry out of the ACC_WIDTH-bit addition (overflow indication)
// Build option: MAC_SATURATE_EN selects clamping instead of modulo wrap.
module acc_add_sat #(
  parameter int ACC_WIDTH = 12
) (
  input  logic [ACC_WIDTH-1:0] i_a,
  input  logic [ACC_WIDTH-1:0] i_b,
  output logic [ACC_WIDTH-1:0] o_sum,
  output logic                 o_carry
);

  logic [ACC_WIDTH:0] full;

  assign full    = {1'b0, i_a} + {1'b0, i_b};
  assign o_carry = full[ACC_WIDTH];

`ifdef MAC_SATURATE_EN
  // Once clamped, the accumulator sits at all-ones; any later non-zero
  // addend carries again, so it stays clamped for the rest of the batch.
  assign o_sum = full[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : full[ACC_WIDTH-1:0];
`else
  assign o_sum = full[ACC_WIDTH-1:0];
`endif

endmodule

// File: rtl/mac_accumulator.sv
// mac_accumulator: sums N_TERMS unsigned products per batch and hands the
// result downstream with a valid/ready handshake.
//   i_clk, i_rst        - clock, asynchronous active-high reset
//   i_valid/o_ready     - upstream product handshake, i_product is 2*WIDTH bits
//   i_clear             - synchronous abort of the batch (wins over everything)
//   o_valid/i_ready     - downstream result handshake
//   o_acc               - running / final sum (ACC_WIDTH bits)
//   o_count             - products accepted in current batch
//   o_overflow          - sticky carry-out flag for the batch
// Build option: MAC_SATURATE_EN (clamp on overflow instead of wrap).
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int N_TERMS   = N_TERMS_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [2*WIDTH-1:0]   i_product,
  input  logic                 i_clear,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [ACC_WIDTH-1:0] o_acc,
  output logic [CNT_W-1:0]     o_count,
  output logic                 o_overflow
);

  state_t               state;
  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH-1:0] sum;
  logic                 carry;
  logic                 accept;
  logic [CNT_W-1:0]     count_nxt;

  assign prod_ext  = ACC_WIDTH'(i_product);
  assign accept    = i_valid & o_ready;
  assign count_nxt = o_count + CNT_W'(1);

  acc_add_sat #(.ACC_WIDTH(ACC_WIDTH)) u_add (
    .i_a     (o_acc),
    .i_b     (prod_ext),
    .o_sum   (sum),
    .o_carry (carry)
  );

  // o_ready / o_valid are registered alongside the state so they are pure
  // decodes of it: ACCUM -> ready, DONE -> valid.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ACCUM;
      o_acc      <= '0;
      o_count    <= '0;
      o_overflow <= 1'b0;
      o_valid    <= 1'b0;
      o_ready    <= 1'b1;
    end else if (i_clear) begin
      state      <= ACCUM;
      o_acc      <= '0;
      o_count    <= '0;
      o_overflow <= 1'b0;
      o_valid    <= 1'b0;
      o_ready    <= 1'b1;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            o_acc      <= sum;
            o_count    <= count_nxt;
            o_overflow <= o_overflow | carry;
            if (count_nxt == CNT_W'(N_TERMS)) begin
              state   <= DONE;
              o_valid <= 1'b1;
              o_ready <= 1'b0;
            end
          end
        end
        DONE: begin
          // Result held until taken; the take cycle accepts nothing.
          if (i_ready) begin
            state      <= ACCUM;
            o_acc      <= '0;
            o_count    <= '0;
            o_overflow <= 1'b0;
            o_valid    <= 1'b0;
            o_ready    <= 1'b1;
          end
        end
        default: begin
          state   <= ACCUM;
          o_valid <= 1'b0;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: a default-parameter instance plus a small
// ACC_WIDTH=8 / N_TERMS=2 instance for overflow behaviour.
module tb_mac_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default instance
  logic        val1 = 0, rdy1 = 1, clr1 = 0;
  logic [7:0]  prod1 = 0;
  logic        ordy1, ov1, ovf1;
  logic [11:0] acc1;
  logic [7:0]  cnt1;

  // small instance
  logic        val2 = 0, rdy2 = 1, clr2 = 0;
  logic [7:0]  prod2 = 0;
  logic        ordy2, ov2, ovf2;
  logic [7:0]  acc2;
  logic [7:0]  cnt2;

  mac_accumulator dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(val1), .o_ready(ordy1),
    .i_product(prod1), .i_clear(clr1), .o_valid(ov1), .i_ready(rdy1),
    .o_acc(acc1), .o_count(cnt1), .o_overflow(ovf1)
  );

  mac_accumulator #(.WIDTH(4), .ACC_WIDTH(8), .N_TERMS(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_valid(val2), .o_ready(ordy2),
    .i_product(prod2), .i_clear(clr2), .o_valid(ov2), .i_ready(rdy2),
    .o_acc(acc2), .o_count(cnt2), .o_overflow(ovf2)
  );

  typedef struct {
    int acc;
    int cnt;
    int ovf;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // scoreboard monitors: compare whenever a result is handed off
  always @(negedge clk) begin
    if (!rst && ov1 && rdy1) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut1_unexpected_result: got acc %0d expected none", acc1);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("dut1_acc", int'(acc1), e.acc);
        chk("dut1_cnt", int'(cnt1), e.cnt);
        chk("dut1_ovf", int'(ovf1), e.ovf);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov2 && rdy2) begin
      if (q2.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut2_unexpected_result: got acc %0d expected none", acc2);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("dut2_acc", int'(acc2), e.acc);
        chk("dut2_cnt", int'(cnt2), e.cnt);
        chk("dut2_ovf", int'(ovf2), e.ovf);
      end
    end
  end

  task automatic send1(input int p);
    val1 = 1; prod1 = 8'(p);
    @(posedge clk); #1;
    val1 = 0;
  endtask

  task automatic send2(input int p);
    val2 = 1; prod2 = 8'(p);
    @(posedge clk); #1;
    val2 = 0;
  endtask

  task automatic idle;
    @(posedge clk); #1;
  endtask

  task automatic push1(input int a, input int c, input int o);
    exp_t e;
    e.acc = a; e.cnt = c; e.ovf = o;
    q1.push_back(e);
  endtask

  task automatic push2(input int a, input int c, input int o);
    exp_t e;
    e.acc = a; e.cnt = c; e.ovf = o;
    q2.push_back(e);
  endtask

  initial begin
    int wrap_exp;
`ifdef MAC_SATURATE_EN
    wrap_exp = 255;
`else
    wrap_exp = 194;
`endif
    // reset state
    #12;
    chk("rst_ready", int'(ordy1), 1);
    chk("rst_valid", int'(ov1), 0);
    chk("rst_acc", int'(acc1), 0);
    @(posedge clk); #1;
    rst = 0;

    // 8 back-to-back products of 225
    push1(1800, 8, 0);
    for (int i = 0; i < 8; i++) send1(225);
    chk("b2b_valid_next_cycle", int'(ov1), 1);
    idle;
    chk("after_take_ready", int'(ordy1), 1);
    chk("after_take_acc", int'(acc1), 0);

    // bubbles between products
    push1(20, 8, 0);
    send1(10);
    for (int i = 0; i < 2; i++) begin idle; chk("bubble_cnt1", int'(cnt1), 1); end
    send1(0);
    for (int i = 0; i < 2; i++) begin idle; chk("bubble_cnt2", int'(cnt1), 2); end
    send1(5);
    for (int i = 0; i < 5; i++) send1(1);
    idle;

    // hold in DONE while downstream stalls
    rdy1 = 0;
    for (int i = 0; i < 8; i++) send1(3);
    for (int i = 0; i < 5; i++) begin
      val1 = 1; prod1 = 8'd7;
      @(posedge clk); #1;
      chk("stall_acc", int'(acc1), 24);
      chk("stall_ready", int'(ordy1), 0);
      chk("stall_cnt", int'(cnt1), 8);
    end
    val1 = 0;
    push1(24, 8, 0);
    rdy1 = 1;
    @(posedge clk); #1;
    chk("release_acc", int'(acc1), 0);
    chk("release_ready", int'(ordy1), 1);

    // clear wins over a simultaneous acceptance
    for (int i = 0; i < 3; i++) send1(9);
    chk("pre_clear_acc", int'(acc1), 27);
    clr1 = 1; val1 = 1; prod1 = 8'd50;
    @(posedge clk); #1;
    clr1 = 0; val1 = 0;
    chk("clear_acc", int'(acc1), 0);
    chk("clear_cnt", int'(cnt1), 0);
    push1(16, 8, 0);
    for (int i = 0; i < 8; i++) send1(2);
    idle;

    // asynchronous reset mid-batch
    send1(4);
    send1(4);
    #2 rst = 1;
    #1;
    chk("async_rst_acc", int'(acc1), 0);
    chk("async_rst_cnt", int'(cnt1), 0);
    chk("async_rst_ready", int'(ordy1), 1);
    chk("async_rst_valid", int'(ov1), 0);
    rst = 0;
    #1;
    chk("post_rst_acc", int'(acc1), 0);
    @(posedge clk); #1;
    send1(6);
    chk("first_after_rst_acc", int'(acc1), 6);
    chk("first_after_rst_cnt", int'(cnt1), 1);
    push1(13, 8, 0);
    for (int i = 0; i < 7; i++) send1(1);
    idle;

    // overflow: ACC_WIDTH=8, N_TERMS=2
    push2(wrap_exp, 2, 1);
    send2(225);
    send2(225);
    chk("ovf_valid", int'(ov2), 1);
    chk("ovf_flag", int'(ovf2), 1);
    idle;
    chk("ovf_cleared_on_take", int'(ovf2), 0);
    push2(150, 2, 0);
    send2(100);
    send2(50);
    idle;

    repeat (3) idle;
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // hard bound on run time
  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 Parameter WIDTH, default 4, SHALL be the operand width of the upstream multiplier; the product is 2*WIDTH bits.
REQ-002 Parameter ACC_WIDTH, default 12, SHALL be the accumulator width; legal range is 2*WIDTH to 32.
REQ-003 Parameter N_TERMS, default 8, SHALL be the number of products summed per batch; legal range is 1 to 255.
REQ-004 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 i_rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 i_valid  input  1  SHALL mean the upstream product is valid.
REQ-007 o_ready  output  1  SHALL mean the block accepts a product this cycle.
REQ-008 i_product  input  2*WIDTH  SHALL be the unsigned product from the upstream array multiplier.
REQ-009 i_clear  input  1  SHALL be a synchronous abort of the current batch.
REQ-010 o_valid  output  1  SHALL mean the batch result is presented.
REQ-011 i_ready  input  1  SHALL mean downstream takes the result.
REQ-012 o_acc  output  ACC_WIDTH  SHALL be the running or final sum.
REQ-013 o_count  output  8  SHALL be the number of products accepted in the current batch.
REQ-014 o_overflow  output  1  SHALL be a sticky flag set when the sum exceeds 2^ACC_WIDTH-1.

Function
REQ-015 The FSM SHALL have two states: ACCUM (o_ready=1, o_valid=0) and DONE (o_ready=0, o_valid=1).
REQ-016 Acceptance SHALL occur only when i_valid and o_ready are both 1; the product SHALL be zero-extended to ACC_WIDTH and added into o_acc at that edge, and o_count SHALL increment (latency 1 cycle).
REQ-017 An acceptance that makes o_count reach N_TERMS SHALL move ACCUM->DONE; o_valid SHALL rise the next cycle with the final o_acc.
REQ-018 In DONE, o_acc, o_count and o_overflow SHALL be held stable until i_ready=1.
REQ-019 In DONE with i_ready=1, the FSM SHALL go to ACCUM with o_acc=0, o_count=0, o_overflow=0; no product SHALL be accepted in that cycle.
REQ-020 i_clear=1 in any state SHALL force ACCUM with o_acc=0, o_count=0, o_overflow=0; clear SHALL win over a simultaneous acceptance or i_ready, and that product SHALL be discarded.
REQ-021 Bubbles (i_valid=0) in ACCUM SHALL leave all state unchanged.
REQ-022 Overflow SHALL be detected from the carry out of the ACC_WIDTH-bit addition; o_overflow SHALL stay set until cleared by REQ-019 or REQ-020.

Reset
REQ-023 i_rst=1 SHALL immediately force ACCUM, o_acc=0, o_count=0, o_overflow=0, o_valid=0, o_ready=1, including mid-batch; the first edge after deassertion SHALL accept normally.

Configuration
REQ-024 When MAC_SATURATE_EN is defined, an overflowing addition SHALL clamp o_acc to all-ones and further additions in that batch SHALL hold all-ones.
REQ-025 When MAC_SATURATE_EN is not defined, o_acc SHALL wrap modulo 2^ACC_WIDTH.
REQ-026 o_overflow SHALL behave identically in both builds.

Structure
REQ-027 Package mac_pkg SHALL hold the FSM state enum (ACCUM, DONE) and the default parameter constants.
REQ-028 The add/saturate datapath SHALL be one sub-module, acc_add_sat, with operands, sum and carry/overflow ports; the FSM and registers SHALL stay in mac_accumulator.

Verification
REQ-029 Defaults, 8 back-to-back products of 225 -> o_valid the cycle after the 8th acceptance, o_acc=1800, o_count=8, o_overflow=0.
REQ-030 Defaults, products 10,0,5 with 2-cycle bubbles between them, then 5 more of 1 -> o_acc=20; o_count SHALL not advance during bubbles.
REQ-031 In DONE, i_ready=0 for 5 cycles -> o_acc stable, o_ready=0, i_valid ignored; then i_ready=1 -> next cycle o_acc=0, o_ready=1.
REQ-032 ACC_WIDTH=8, N_TERMS=2, products 225,225 -> wrap build o_acc=194, saturate build o_acc=255; o_overflow=1 in both.
REQ-033 After 3 acceptances, i_clear=1 together with i_valid=1 -> o_acc=0, o_count=0, product discarded.
REQ-034 i_rst pulsed asynchronously mid-batch (between clock edges) -> all outputs at reset values before the next edge.
